mult4_mac_stage: RTL and testbench
==================================

# mult4_mac_stage

Sequential multiply-accumulate stage directly downstream of the team's 4x4 combinational tree multiplier (`main`, Wallace/Dadda reduction plus prefix adder). It accepts a stream of 4-bit operand pairs over a valid/ready handshake and registers each pair. It drives the registered pair into a `main` instance and accumulates the 8-bit products into a group sum. On the beat marked `last`, it presents the group sum, beat count and overflow flag on a held output handshake.

## Interface
- `ACC_W`, default 16: accumulator and result width in bits. Legal range 8..32.
- `clk`  in  1: the single clock. All state updates on the rising edge.
- `rst`  in  1: reset, synchronous and active-high.
- `in_valid`  in  1: operand beat valid.
- `in_ready`  out  1: stage can accept a beat this cycle.
- `in_x`  in  4: multiplicand, unsigned.
- `in_y`  in  4: multiplier, unsigned.
- `in_last`  in  1: the beat closes the current group.
- `out_valid`  out  1: a result is held.
- `out_ready`  in  1: the consumer takes the result.
- `out_acc`  out  ACC_W: group sum of products, modulo 2^ACC_W.
- `out_count`  out  8: number of beats in the group, saturating at 255.
- `out_ovf`  out  1: sticky flag, set when the group sum wrapped.

## Operation
- Beat transfer occurs when `in_valid && in_ready`. The beat is captured into stage-1 registers `s1_x`, `s1_y`, `s1_last` and `s1_valid`.
- The stage-1 registers drive the `main` instance combinationally, giving `prod[7:0] = s1_x*s1_y`. The product has range 0..225.
- Stage-1 drain condition `s1_fire = s1_valid && (!s1_last || !out_valid || out_ready)`. A non-last beat always drains. A last beat drains only when the output slot is free or being freed in the same cycle.
- `in_ready = !s1_valid || s1_fire`. In-place refill is allowed, so the stage sustains one beat per cycle.
- On `s1_fire` with a non-last beat:
  - `acc <= acc + prod`, zero-extended, wrapping modulo 2^ACC_W.
  - `ovf <= ovf | carry-out`.
  - `cnt <= min(cnt+1, 255)`.
- On `s1_fire` with a last beat:
  - The output registers load `acc+prod`, the updated `ovf` and the updated `cnt`.
  - `out_valid <= 1`.
  - `acc`, `ovf` and `cnt` clear to 0 on the same edge, so the next group starts clean.
- Output handshake:
  - `out_valid` clears on `out_ready` unless a new last beat loads in the same cycle; load wins.
  - Output fields are stable while `out_valid && !out_ready`.
- Group state machine, derived from `cnt` and `s1_valid`:
  - IDLE: no beats of the current group absorbed. Goes to ACCUM on a non-last drain, or stays in IDLE on a last drain (emits a result).
  - ACCUM: group in progress. Returns to IDLE on a last drain.
- A single-beat group (`in_last` on the first beat) is legal and yields `out_count` = 1.
- `in_x`, `in_y` and `in_last` are ignored when `in_valid` = 0.

## Timing
- Reset values: `in_ready` = 1, `out_valid` = 0, `out_acc` = 0, `out_count` = 0, `out_ovf` = 0. `s1_valid`, `acc`, `cnt` and `ovf` all clear to 0.
- Reset mid-group discards the partial sum and any held result. The first beat after reset begins a new group.
- Latency: a last beat accepted at edge N drives `out_valid` = 1 after edge N+1, provided the output slot is free.
- Throughput: one beat per cycle while the output is not blocked.
- Backpressure:
  - With `out_valid` = 1, `out_ready` = 0 and a last beat in stage 1, the last beat stalls and `in_ready` = 0.
  - Stage 1 refills in the cycle `out_ready` rises.
- The critical path is the stage-1 register, through `main`, through the ACC_W-bit adder, to `acc`. No further register stages are allowed.

## Structure
- Shared package `mult4_pkg` holds:
  - `OP_W` = 4 and `PROD_W` = 8.
  - `CNT_W` = 8 and `CNT_MAX` = 255.
  - A struct or typedef for the result bundle `{acc, count, ovf}`.
- One sub-module: the existing multiplier `main`, instantiated unchanged as `u_mul`. It is not duplicated inline.
- The accumulator adder is behavioural `+` with an explicit ACC_W+1 result so the carry-out is available.

## Test plan
- Group (3,5), (15,15), (0,7,last) back-to-back, `out_ready` = 1 → one result: `out_acc` = 240, `out_count` = 3, `out_ovf` = 0, `out_valid` 1 cycle after the last beat.
- Exhaustive single-beat groups for all 256 (x,y) pairs → each `out_acc` = x*y and `out_count` = 1. This checks `main` end to end.
- `ACC_W` = 8 with (15,15), (15,15,last) → `out_acc` = 194, `out_ovf` = 1, `out_count` = 2. The next group (1,1,last) → `out_acc` = 1, `out_ovf` = 0.
- Hold `out_ready` = 0 after result A, then stream group B ending in last → `in_ready` drops when B's last reaches stage 1, and A stays stable. Raise `out_ready` → A taken, then B presented the next cycle, with no beat lost.
- 300 beats of (1,1) with the last on beat 300 → `out_acc` = 300 and `out_count` = 255 (saturated).
- Assert `rst` for one cycle after two beats of a group, then send (2,3,last) → `out_acc` = 6, `out_count` = 1. All outputs are at reset values during and right after `rst`.

Source files
------------

// File: rtl/mult4_pkg.sv
// mult4_pkg: shared widths and result bundle for the 4x4 multiplier and its MAC stage
package mult4_pkg;
  localparam int OP_W = 4;
  localparam int PROD_W = 8;
  localparam int CNT_W = 8;
  localparam int ACC_MAX_W = 32;
  localparam logic [CNT_W-1:0] CNT_MAX = 8'd255;
  typedef struct packed {
    logic [ACC_MAX_W-1:0] acc;
    logic [CNT_W-1:0]     count;
    logic                 ovf;
  } result_t;
endpackage

// File: rtl/mult4_mac_stage_main.sv
// main: 4x4 unsigned tree multiplier, two carry-save layers and a Kogge-Stone final adder
module main
  import mult4_pkg::*;
(
  input  logic [OP_W-1:0]   x,
  input  logic [OP_W-1:0]   y,
  output logic [PROD_W-1:0] p
);
  logic [PROD_W-1:0] pp [OP_W];
  logic [PROD_W-1:0] s1, c1, s2, c2;
  logic [PROD_W-1:0] g0, g1, g2, g3, p0, q1, q2;
  for (genvar i = 0; i < OP_W; i++) begin : g_pp
    assign pp[i] = {{(PROD_W-OP_W){1'b0}}, x & {OP_W{y[i]}}} << i;
  end
  // The product never exceeds 8 bits, so dropping carries past the MSB is exact.
  always_comb begin
    s1 = pp[0] ^ pp[1] ^ pp[2];
    c1 = ((pp[0] & pp[1]) | (pp[0] & pp[2]) | (pp[1] & pp[2])) << 1;
    s2 = s1 ^ c1 ^ pp[3];
    c2 = ((s1 & c1) | (s1 & pp[3]) | (c1 & pp[3])) << 1;
    g0 = s2 & c2;
    p0 = s2 ^ c2;
    g1 = g0 | (p0 & (g0 << 1));
    q1 = p0 & (p0 << 1);
    g2 = g1 | (q1 & (g1 << 2));
    q2 = q1 & (q1 << 2);
    g3 = g2 | (q2 & (g2 << 4));
    p = p0 ^ (g3 << 1);
  end
endmodule

// File: rtl/mult4_mac_stage.sv
// mult4_mac_stage: registers operand beats, multiplies them and accumulates per-group sums
module mult4_mac_stage
  import mult4_pkg::*;
#(
  parameter int ACC_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [3:0]       in_x,
  input  logic [3:0]       in_y,
  input  logic             in_last,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [ACC_W-1:0] out_acc,
  output logic [7:0]       out_count,
  output logic             out_ovf
);
  logic [OP_W-1:0]   s1_x, s1_y;
  logic              s1_last, s1_valid, s1_fire;
  logic [PROD_W-1:0] prod;
  logic [ACC_W-1:0]  acc;
  logic [ACC_W:0]    sum;
  logic [CNT_W-1:0]  cnt, cnt_n;
  logic              ovf, ovf_n;
  result_t           res;
  main u_mul (.x(s1_x), .y(s1_y), .p(prod));
  always_comb begin
    s1_fire = s1_valid && (!s1_last || !out_valid || out_ready);
    in_ready = !s1_valid || s1_fire;
    sum = {1'b0, acc} + (ACC_W+1)'(prod);
    ovf_n = ovf | sum[ACC_W];
    cnt_n = (cnt == CNT_MAX) ? cnt : cnt + 1'b1;
  end
  assign out_acc = ACC_W'(res.acc);
  assign out_count = res.count;
  assign out_ovf = res.ovf;
  always_ff @(posedge clk) begin
    if (rst) begin
      s1_valid <= 1'b0;
      acc <= '0;
      cnt <= '0;
      ovf <= 1'b0;
      out_valid <= 1'b0;
      res <= '0;
    end else begin
      if (in_ready) begin
        s1_valid <= in_valid;
        if (in_valid) begin
          s1_x <= in_x;
          s1_y <= in_y;
          s1_last <= in_last;
        end
      end
      // A last beat hands the group to the output and restarts the accumulator.
      if (s1_fire) begin
        acc <= s1_last ? '0 : sum[ACC_W-1:0];
        cnt <= s1_last ? '0 : cnt_n;
        ovf <= s1_last ? 1'b0 : ovf_n;
        if (s1_last) res <= '{acc: ACC_MAX_W'(sum[ACC_W-1:0]), count: cnt_n, ovf: ovf_n};
      end
      out_valid <= (s1_fire && s1_last) ? 1'b1 : (out_ready ? 1'b0 : out_valid);
    end
  end
endmodule

// File: tb/tb_mult4_mac_stage.sv
// tb_mult4_mac_stage: scoreboard bench driving a 16-bit and an 8-bit accumulator instance in lockstep
module tb_mult4_mac_stage;
  typedef struct {longint sum; int cnt;} exp_t;
  logic clk = 0, rst = 1;
  logic in_valid = 0, in_last = 0, out_ready = 0;
  logic [3:0] in_x = 0, in_y = 0;
  logic in_ready16, in_ready8, out_valid16, out_valid8, ovf16, ovf8;
  logic [15:0] acc16;
  logic [7:0] acc8, cnt16, cnt8;
  int vecs = 0, errs = 0, last_wait = 0, pcnt = 0;
  longint psum = 0;
  bit rnd_rdy = 0;
  exp_t q16[$], q8[$];
  logic hold16 = 0;
  logic [15:0] held_acc;
  logic [7:0] held_cnt;

  always #5 clk = ~clk;

  mult4_mac_stage #(.ACC_W(16)) dut16 (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready16), .in_x(in_x), .in_y(in_y),
    .in_last(in_last), .out_valid(out_valid16), .out_ready(out_ready), .out_acc(acc16),
    .out_count(cnt16), .out_ovf(ovf16));
  mult4_mac_stage #(.ACC_W(8)) dut8 (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready8), .in_x(in_x), .in_y(in_y),
    .in_last(in_last), .out_valid(out_valid8), .out_ready(out_ready), .out_acc(acc8),
    .out_count(cnt8), .out_ovf(ovf8));

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    vecs++;
    if (act !== exp) begin
      errs++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  task automatic check_out(input string tag, input int w, input logic [31:0] acc,
                           input logic [7:0] cnt, input logic ovf, input exp_t e);
    longint m = longint'(1) << w;
    chk({tag, " acc"}, acc, 32'(e.sum % m));
    chk({tag, " count"}, 32'(cnt), 32'((e.cnt > 255) ? 255 : e.cnt));
    chk({tag, " ovf"}, 32'(ovf), 32'(e.sum >= m));
  endtask

  task automatic check_reset(input string tag);
    chk({tag, " in_ready"}, 32'(in_ready16 & in_ready8), 1);
    chk({tag, " out_valid"}, 32'(out_valid16 | out_valid8), 0);
    chk({tag, " out_acc"}, 32'(acc16) | 32'(acc8), 0);
    chk({tag, " out_count"}, 32'(cnt16) | 32'(cnt8), 0);
    chk({tag, " out_ovf"}, 32'(ovf16 | ovf8), 0);
  endtask

  // Model: a group is just the plain sum of x*y and the beat count; widths apply at check time.
  task automatic beat(input int x, input int y, input bit last);
    bit taken = 0;
    int n = 0;
    in_valid = 1; in_x = 4'(x); in_y = 4'(y); in_last = last;
    while (!taken && n < 1000) begin
      if (rnd_rdy) out_ready = 1'($urandom_range(0, 1));
      @(negedge clk);
      taken = in_ready16;
      @(posedge clk); #1;
      n++;
    end
    last_wait = n;
    if (!taken) chk("beat accept timeout", 0, 1);
    else begin
      psum += x * y;
      pcnt++;
      if (last) begin
        q16.push_back('{psum, pcnt});
        q8.push_back('{psum, pcnt});
        psum = 0;
        pcnt = 0;
      end
    end
  endtask

  task automatic drain();
    int n = 0;
    in_valid = 0; out_ready = 1; rnd_rdy = 0;
    while ((q16.size() != 0 || q8.size() != 0 || out_valid16) && n < 200) begin
      @(posedge clk); #1;
      n++;
    end
    chk("drain within budget", 32'(n < 200), 1);
  endtask

  always @(negedge clk) begin
    if (!rst && out_valid16 && out_ready) begin
      if (q16.size() == 0) chk("unexpected result16", 1, 0);
      else check_out("res16", 16, 32'(acc16), cnt16, ovf16, q16.pop_front());
    end
    if (!rst && out_valid8 && out_ready) begin
      if (q8.size() == 0) chk("unexpected result8", 1, 0);
      else check_out("res8", 8, 32'(acc8), cnt8, ovf8, q8.pop_front());
    end
    if (!rst && hold16) begin
      chk("held out_valid", 32'(out_valid16), 1);
      chk("held out_acc", 32'(acc16), 32'(held_acc));
      chk("held out_count", 32'(cnt16), 32'(held_cnt));
    end
    hold16 <= !rst && out_valid16 && !out_ready;
    held_acc <= acc16;
    held_cnt <= cnt16;
  end

  initial begin
    #200000;
    $display("FAIL watchdog expired: got timeout, expected completion");
    $fatal(1);
  end

  initial begin
    repeat (2) @(posedge clk);
    #1;
    check_reset("reset");
    rst = 0;
    out_ready = 1;
    beat(3, 5, 0); beat(15, 15, 0); beat(0, 7, 1);
    in_valid = 0;
    chk("latency out_valid before", 32'(out_valid16), 0);
    @(posedge clk); #1;
    chk("latency out_valid after", 32'(out_valid16), 1);
    drain();
    for (int x = 0; x < 16; x++)
      for (int y = 0; y < 16; y++) beat(x, y, 1);
    drain();
    beat(15, 15, 0); beat(15, 15, 1); beat(1, 1, 1);
    drain();
    out_ready = 0;
    beat(2, 2, 1); beat(1, 2, 0); beat(3, 4, 1);
    in_valid = 0;
    for (int i = 0; i < 3; i++) begin
      chk("stall in_ready", 32'(in_ready16), 0);
      chk("stall out_valid", 32'(out_valid16), 1);
      chk("stall out_acc", 32'(acc16), 4);
      @(posedge clk); #1;
    end
    out_ready = 1;
    beat(5, 5, 1);
    chk("refill on out_ready", 32'(last_wait), 1);
    drain();
    for (int i = 1; i <= 300; i++) beat(1, 1, i == 300);
    drain();
    rnd_rdy = 1;
    for (int i = 0; i < 300; i++)
      beat($urandom_range(0, 15), $urandom_range(0, 15), i == 299 || $urandom_range(0, 3) == 0);
    drain();
    beat(2, 2, 0); beat(3, 3, 0);
    in_valid = 0;
    rst = 1;
    psum = 0;
    pcnt = 0;
    @(posedge clk); #1;
    check_reset("during rst");
    rst = 0;
    @(posedge clk); #1;
    check_reset("after rst");
    beat(2, 3, 1);
    drain();
    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end
endmodule
